vram_sync_ctrl: RTL and testbench

VRAM_SYNC_CTRL -- requirements
Module: vram_sync_ctrl

---
 rtl/vram_sync_ctrl.sv | 106 ++++++++++
 tb/tb_vram_sync_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vram_sync_ctrl.sv
// Copies the whole CPU-facing VRAM into the PPU-facing VRAM, one word per cycle,
// starting at the first vblank after a CPU sync request.
module vram_sync_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sync_req,
  input  logic              i_vblank_start,
  output logic [ADDR_W-1:0] o_src_addr,
  output logic              o_src_rden,
  input  logic [DATA_W-1:0] i_src_rddata,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic              o_dst_wren,
  output logic [DATA_W-1:0] o_dst_wrdata,
  output logic              o_cpu_lock,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pending,
  output logic [1:0]        o_fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rden;
  logic [ADDR_W-1:0] dst_addr;
  logic              dst_wren;
  logic              busy;
  logic              done;
  logic              pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_addr <= '0;
      src_rden <= 1'b0;
      dst_addr <= '0;
      dst_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pending  <= 1'b0;
    end else begin
      dst_wren <= src_rden;
      dst_addr <= src_addr;
      case (state)
        IDLE: begin
          if (i_vblank_start && (pending || i_sync_req)) begin
            state    <= COPY;
            src_addr <= '0;
            src_rden <= 1'b1;
            busy     <= 1'b1;
            pending  <= 1'b0;
          end else if (i_sync_req) begin
            pending <= 1'b1;
          end
        end
        COPY: begin
          if (i_sync_req) pending <= 1'b1;
          // Hold the address at the last word so the counter never wraps.
          if (src_addr == LAST_ADDR) begin
            state    <= DRAIN;
            src_rden <= 1'b0;
          end else begin
            src_addr <= src_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (i_sync_req) pending <= 1'b1;
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          if (i_sync_req) pending <= 1'b1;
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Source reads have one cycle of latency, so read data lines up with the
  // registered write strobe and is forwarded straight to the destination.
  assign o_dst_wrdata = dst_wren ? i_src_rddata : '0;
  assign o_src_addr   = src_addr;
  assign o_src_rden   = src_rden;
  assign o_dst_addr   = dst_addr;
  assign o_dst_wren   = dst_wren;
  assign o_busy       = busy;
  assign o_cpu_lock   = busy;
  assign o_done       = done;
  assign o_pending    = pending;
  assign o_fsm_state  = state;

endmodule

// File: tb/tb_vram_sync_ctrl.sv
// Scoreboard bench for vram_sync_ctrl with a 16-word VRAM: directed copies,
// ignored vblanks, requests during a copy, and reset abort.
module tb_vram_sync_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int EW     = 32 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sync_req = 1'b0;
  logic              vblank = 1'b0;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rden;
  logic [DATA_W-1:0] src_rddata = '0;
  logic [ADDR_W-1:0] dst_addr;
  logic              dst_wren;
  logic [DATA_W-1:0] dst_wrdata;
  logic              cpu_lock, busy, done, pending;
  logic [1:0]        fsm_state;

  logic [DATA_W-1:0] src_mem [DEPTH];
  logic [EW-1:0]     exp_q[$];
  int                done_q[$];
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;

  vram_sync_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .i_sync_req(sync_req), .i_vblank_start(vblank),
    .o_src_addr(src_addr), .o_src_rden(src_rden), .i_src_rddata(src_rddata),
    .o_dst_addr(dst_addr), .o_dst_wren(dst_wren), .o_dst_wrdata(dst_wrdata),
    .o_cpu_lock(cpu_lock), .o_busy(busy), .o_done(done), .o_pending(pending),
    .o_fsm_state(fsm_state)
  );

  // Clock, cycle counter and a synchronous-read model of the source VRAM.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_rden) src_rddata <= src_mem[src_addr];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_src(input logic [DATA_W-1:0] base);
    for (int k = 0; k < DEPTH; k++) src_mem[k] = base | DATA_W'(k);
  endtask

  // Expected writes for a copy whose start condition is seen in cycle t.
  task automatic push_copy(input int t, input int nwords, input bit with_done);
    for (int k = 0; k < nwords; k++)
      exp_q.push_back({32'(t + 2 + k), ADDR_W'(k), src_mem[k]});
    if (with_done) done_q.push_back(t + DEPTH + 2);
  endtask

  // Monitor: pops expectations whenever the DUT writes or pulses done.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int d;
    if (dst_wren) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {cyc, dst_addr}, 0);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 128'(cyc), 128'(e[EW-1 -: 32]));
        check("write_addr", 128'(dst_addr), 128'(e[DATA_W +: ADDR_W]));
        check("write_data", 128'(dst_wrdata), 128'(e[DATA_W-1:0]));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 128'(cyc), 0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", 128'(cyc), 128'(d));
      end
    end
  end

  initial begin
    int t;
    load_src(64'hA500_0000_0000_0000);
    tick(); tick();
    rst = 1'b0;
    check("reset_outputs", {src_rden, src_addr, dst_wren, dst_addr, dst_wrdata,
                            cpu_lock, busy, done, pending, fsm_state}, 0);

    // Basic copy: request, then vblank in cycle t.
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    check("pending_latched", 128'(pending), 1);
    vblank = 1'b1; t = cyc; push_copy(t, DEPTH, 1'b1);
    tick(); vblank = 1'b0;
    check("first_read", {busy, cpu_lock, src_rden, src_addr, pending}, {1'b1, 1'b1, 1'b1, 4'd0, 1'b0});
    repeat (17) tick();
    check("busy_at_done", {busy, cpu_lock, fsm_state}, {1'b1, 1'b1, 2'd3});
    tick();
    check("idle_after_copy", {busy, cpu_lock, src_rden, dst_wren, fsm_state}, 0);
    repeat (3) tick();

    // Vblank without a request is ignored for 20 cycles.
    vblank = 1'b1; tick(); vblank = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("ignored_vblank", {src_rden, dst_wren, busy, pending}, 0);
      tick();
    end

    // Request and vblank in the same cycle.
    load_src(64'h5A00_0000_0000_0000);
    sync_req = 1'b1; vblank = 1'b1; t = cyc; push_copy(t, DEPTH, 1'b1);
    tick(); sync_req = 1'b0; vblank = 1'b0;
    check("same_cycle_start", {busy, src_rden, pending}, {1'b1, 1'b1, 1'b0});
    repeat (10) tick();
    check("same_cycle_no_pending", 128'(pending), 0);
    repeat (10) tick();

    // Request during a copy; a stray vblank mid-copy must not restart it.
    load_src(64'hA500_0000_0000_0000);
    vblank = 1'b1; sync_req = 1'b1; t = cyc; push_copy(t, DEPTH, 1'b1);
    tick(); vblank = 1'b0; sync_req = 1'b0;
    repeat (4) tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    check("pending_during_copy", 128'(pending), 1);
    repeat (4) tick();
    vblank = 1'b1; tick(); vblank = 1'b0;
    repeat (10) tick();
    check("pending_after_copy", {pending, busy}, {1'b1, 1'b0});
    repeat (2) tick();
    load_src(64'h0123_4567_89AB_CDE0);
    vblank = 1'b1; t = cyc; push_copy(t, DEPTH, 1'b1);
    tick(); vblank = 1'b0;
    check("second_copy_start", {busy, src_rden, pending}, {1'b1, 1'b1, 1'b0});
    repeat (22) tick();

    // Reset in cycle t+8 of a copy aborts it after word 6.
    load_src(64'hA500_0000_0000_0000);
    sync_req = 1'b1; vblank = 1'b1; t = cyc; push_copy(t, 7, 1'b0);
    tick(); sync_req = 1'b0; vblank = 1'b0;
    repeat (2) tick();
    sync_req = 1'b1; tick(); sync_req = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("after_abort", {src_rden, src_addr, dst_wren, dst_addr, dst_wrdata,
                            cpu_lock, busy, done, pending, fsm_state}, 0);
      tick();
    end

    check("writes_outstanding", 128'(exp_q.size()), 0);
    check("done_outstanding", 128'(done_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
